// File: rtl/dyn_phase_resp_if.sv
// dyn_phase_resp_if: dynamic phase-shift handshake between a PLL controller (master) and responder (slave).
interface dyn_phase_resp_if;
  logic       PHASESTEP;
  logic       PHASEUPDOWN;
  logic [3:0] PHASECOUNTERSELECT;
  logic       PHASEDONE;
  modport master(output PHASESTEP, PHASEUPDOWN, PHASECOUNTERSELECT, input PHASEDONE);
  modport slave(input PHASESTEP, PHASEUPDOWN, PHASECOUNTERSELECT, output PHASEDONE);
endinterface

// File: rtl/dyn_phase_resp.sv
// dyn_phase_resp: PLL-side phase-step responder tracking M/C0..C4 offsets.
// Define DYN_PHASE_RESP_STEPCNT_EN to add the STEP_CNT/ERR_CNT event counters.
module dyn_phase_resp #(
  parameter int PW          = 3,
  parameter int PHASE_STEPS = 8,
  parameter int SAMPLE_DLY  = 1,
  parameter int BUSY_CYC    = 4
) (
  input  logic            CLK50M,
  input  logic            RESET_N,
  dyn_phase_resp_if.slave b,
  input  logic            ERR_CLR,
  output logic [6*PW-1:0] PHASE_VEC,
  output logic            ERR
`ifdef DYN_PHASE_RESP_STEPCNT_EN
  ,
  output logic [15:0]     STEP_CNT,
  output logic [7:0]      ERR_CNT
`endif
);
  localparam int CMAX = (SAMPLE_DLY > BUSY_CYC) ? SAMPLE_DLY : BUSY_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [PW-1:0] TOP = PW'(PHASE_STEPS - 1);
  typedef enum logic [1:0] {IDLE, SAMPLE, BUSY, WAIT_REL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0][PW-1:0] off_q, off_d;
  logic [3:0] sel_q, sel_d;
  logic up_q, up_d, done_q, done_d, err_q, err_d, step_q;
  logic rise, latch, abort, apply, new_err;
  function automatic logic [PW-1:0] step_off(input logic [PW-1:0] o, input logic up);
    return up ? ((o == TOP) ? '0 : o + PW'(1)) : ((o == '0) ? TOP : o - PW'(1));
  endfunction
  assign rise = b.PHASESTEP & ~step_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    up_d = up_q;
    sel_d = sel_q;
    done_d = done_q;
    latch = 1'b0;
    abort = 1'b0;
    apply = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        cnt_d = CW'(SAMPLE_DLY);
        state_d = SAMPLE;
        latch = (SAMPLE_DLY == 0);
      end
      SAMPLE: begin
        cnt_d = cnt_q - CW'(1);
        abort = !b.PHASESTEP;
        latch = b.PHASESTEP && cnt_q == CW'(1);
        state_d = abort ? IDLE : SAMPLE;
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        apply = cnt_q == CW'(1);
        state_d = !apply ? BUSY : b.PHASESTEP ? WAIT_REL : IDLE;
        done_d = apply;
      end
      WAIT_REL: state_d = b.PHASESTEP ? WAIT_REL : IDLE;
      default: state_d = IDLE;
    endcase
    if (latch) begin
      up_d = b.PHASEUPDOWN;
      sel_d = b.PHASECOUNTERSELECT;
      cnt_d = CW'(BUSY_CYC);
      done_d = 1'b0;
      state_d = BUSY;
    end
    // a new error always beats a simultaneous clear
    new_err = abort | (rise && (state_q == BUSY || state_q == WAIT_REL)) | (apply && sel_q > 4'd6);
    err_d = new_err | (err_q & ~ERR_CLR);
    for (int i = 0; i < 6; i++)
      off_d[i] = (apply && (sel_q == 4'd0 || sel_q == 4'(i + 1))) ? step_off(off_q[i], up_q) : off_q[i];
  end
  always_ff @(posedge CLK50M or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q <= '0;
      off_q <= '0;
      sel_q <= '0;
      up_q <= 1'b0;
      done_q <= 1'b1;
      err_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      off_q <= off_d;
      sel_q <= sel_d;
      up_q <= up_d;
      done_q <= done_d;
      err_q <= err_d;
      step_q <= b.PHASESTEP;
    end
  assign b.PHASEDONE = done_q;
  assign PHASE_VEC = off_q;
  assign ERR = err_q;
`ifdef DYN_PHASE_RESP_STEPCNT_EN
  logic [15:0] step_cnt_q, step_cnt_d, sc_base;
  logic [7:0] err_cnt_q, err_cnt_d, ec_base;
  always_comb begin
    sc_base = ERR_CLR ? '0 : step_cnt_q;
    ec_base = ERR_CLR ? '0 : err_cnt_q;
    step_cnt_d = sc_base + 16'(apply && sel_q <= 4'd6 && sc_base != '1);
    err_cnt_d = ec_base + 8'(new_err && ec_base != '1);
  end
  always_ff @(posedge CLK50M or negedge RESET_N)
    if (!RESET_N) begin
      step_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  assign STEP_CNT = step_cnt_q;
  assign ERR_CNT = err_cnt_q;
`endif
endmodule

// File: tb/tb_dyn_phase_resp.sv
// tb_dyn_phase_resp: directed phase steps; a monitor scores every completed PHASEDONE pulse.
module tb_dyn_phase_resp;
  logic CLK50M = 1'b0;
  logic RESET_N = 1'b0;
  logic ERR_CLR = 1'b0;
  logic [17:0] PHASE_VEC;
  logic ERR;
`ifdef DYN_PHASE_RESP_STEPCNT_EN
  logic [15:0] STEP_CNT;
  logic [7:0] ERR_CNT;
`endif
  dyn_phase_resp_if bus();
  dyn_phase_resp dut (
    .CLK50M(CLK50M),
    .RESET_N(RESET_N),
    .b(bus.slave),
    .ERR_CLR(ERR_CLR),
    .PHASE_VEC(PHASE_VEC),
    .ERR(ERR)
`ifdef DYN_PHASE_RESP_STEPCNT_EN
    ,
    .STEP_CNT(STEP_CNT),
    .ERR_CNT(ERR_CNT)
`endif
  );
  always #10 CLK50M = ~CLK50M;
  typedef struct {
    int lat;
    int width;
    logic [17:0] vec;
    logic err;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int raise_cyc = 0;
  always @(posedge CLK50M) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin : monitor
    int fall_cyc;
    logic prev;
    exp_t e;
    fall_cyc = 0;
    prev = 1'b1;
    forever begin
      @(negedge CLK50M);
      if (!RESET_N) prev = 1'b1;
      else begin
        if (prev && !bus.PHASEDONE) fall_cyc = cyc;
        if (!prev && bus.PHASEDONE) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: handshake completed with no step expected at cycle %0d", cyc);
          end else begin
            e = q.pop_front();
            chk("latency", fall_cyc - raise_cyc, e.lat);
            chk("low_width", cyc - fall_cyc, e.width);
            chk("phase_vec", PHASE_VEC, e.vec);
            chk("err", ERR, e.err);
          end
        end
        prev = bus.PHASEDONE;
      end
    end
  end
  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge CLK50M);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d handshakes still outstanding", q.size());
      q.delete();
    end
    repeat (2) @(posedge CLK50M);
  endtask
  task automatic do_step(input logic [3:0] sel, input logic up, input int up_dly, input int hold, input exp_t e);
    q.push_back(e);
    @(posedge CLK50M); #1;
    bus.PHASECOUNTERSELECT = sel;
    bus.PHASEUPDOWN = (up_dly == 0) ? up : ~up;
    bus.PHASESTEP = 1'b1;
    raise_cyc = cyc;
    for (int i = 1; i < hold; i++) begin
      @(posedge CLK50M); #1;
      if (i == up_dly) bus.PHASEUPDOWN = up;
    end
    @(posedge CLK50M); #1;
    bus.PHASESTEP = 1'b0;
    drain();
  endtask
  task automatic pulse_clr();
    @(posedge CLK50M); #1;
    ERR_CLR = 1'b1;
    @(posedge CLK50M); #1;
    ERR_CLR = 1'b0;
  endtask
  task automatic do_reset();
    @(posedge CLK50M); #5;
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK50M);
    #5 RESET_N = 1'b1;
  endtask
  initial begin
    bus.PHASESTEP = 1'b0;
    bus.PHASEUPDOWN = 1'b0;
    bus.PHASECOUNTERSELECT = 4'd0;
    repeat (3) @(posedge CLK50M);
    #5 RESET_N = 1'b1;
    @(negedge CLK50M);
    chk("reset_done", bus.PHASEDONE, 1);
    chk("reset_vec", PHASE_VEC, 0);
    chk("reset_err", ERR, 0);
    do_step(4'd2, 1'b1, 1, 4, exp_t'{2, 4, 18'o000010, 1'b0});
    for (int k = 1; k <= 9; k++)
      do_step(4'd3, 1'b1, 0, 3, exp_t'{2, 4, {9'd0, 3'(k), 6'o10}, 1'b0});
    do_step(4'd3, 1'b0, 0, 3, exp_t'{2, 4, 18'o000010, 1'b0});
    do_reset();
    @(negedge CLK50M);
    chk("rereset_vec", PHASE_VEC, 0);
    do_step(4'd0, 1'b0, 0, 10, exp_t'{2, 4, 18'o777777, 1'b0});
    do_step(4'd9, 1'b1, 0, 3, exp_t'{2, 4, 18'o777777, 1'b1});
    pulse_clr();
    @(negedge CLK50M);
    chk("err_clr", ERR, 0);
    @(posedge CLK50M); #1;
    bus.PHASESTEP = 1'b1;
    @(posedge CLK50M); #1;
    bus.PHASESTEP = 1'b0;
    repeat (4) @(posedge CLK50M);
    @(negedge CLK50M);
    chk("abort_err", ERR, 1);
    chk("abort_vec", PHASE_VEC, 18'o777777);
    chk("abort_done", bus.PHASEDONE, 1);
    pulse_clr();
    q.push_back(exp_t'{2, 4, 18'o777770, 1'b1});
    @(posedge CLK50M); #1;
    bus.PHASECOUNTERSELECT = 4'd1;
    bus.PHASEUPDOWN = 1'b1;
    bus.PHASESTEP = 1'b1;
    raise_cyc = cyc;
    repeat (3) begin @(posedge CLK50M); #1; end
    bus.PHASESTEP = 1'b0;
    @(posedge CLK50M); #1;
    bus.PHASESTEP = 1'b1;
    repeat (2) begin @(posedge CLK50M); #1; end
    bus.PHASESTEP = 1'b0;
    drain();
    chk("dbl_edge_vec", PHASE_VEC, 18'o777770);
    pulse_clr();
    @(posedge CLK50M); #1;
    bus.PHASECOUNTERSELECT = 4'd2;
    bus.PHASEUPDOWN = 1'b1;
    bus.PHASESTEP = 1'b1;
    for (int i = 0; i < 10 && bus.PHASEDONE; i++) @(negedge CLK50M);
    chk("busy_reached", bus.PHASEDONE, 0);
    #3 RESET_N = 1'b0;
    #1;
    chk("rst_busy_done", bus.PHASEDONE, 1);
    chk("rst_busy_vec", PHASE_VEC, 0);
    chk("rst_busy_err", ERR, 0);
    bus.PHASESTEP = 1'b0;
    @(negedge CLK50M);
    @(posedge CLK50M);
    #5 RESET_N = 1'b1;
    do_step(4'd6, 1'b1, 0, 3, exp_t'{2, 4, 18'o100000, 1'b0});
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
